// File: rtl/stream_mask_unit_if.sv
// Beat, mask-write and status signals of stream_mask_unit.
// master = producer/consumer side (bench), slave = the unit.
interface stream_mask_unit_if #(
  parameter int unsigned BUS_W = 256,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned NW    = 32
);
  logic             mask_wr_en;
  logic [SEL_W-1:0] mask_wr_addr;
  logic [BUS_W-1:0] mask_wr_data;

  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic [1:0]       in_mode;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;
  logic [NW-1:0]    out_zero;
  logic             out_last;
  logic [15:0]      out_beat_cnt;
  logic             err_sel;

  modport master (
    output mask_wr_en, mask_wr_addr, mask_wr_data,
    output in_valid, in_data, in_sel, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_last, out_beat_cnt, err_sel
  );

  modport slave (
    input  mask_wr_en, mask_wr_addr, mask_wr_data,
    input  in_valid, in_data, in_sel, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_last, out_beat_cnt, err_sel
  );
endinterface

// File: rtl/stream_mask_unit.sv
// Two-stage back-pressured packet masker: stage 1 captures beat and selected
// mask set, stage 2 applies the per-beat mode and flags all-zero words.
module stream_mask_unit #(
  parameter int unsigned PACKET_LENGTH = 8,
  parameter int unsigned W             = 8,
  parameter int unsigned K_MAX         = 4,
  parameter int unsigned MASK_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  stream_mask_unit_if.slave  bus
);
  localparam int unsigned NW    = W * K_MAX;
  localparam int unsigned BUS_W = NW * PACKET_LENGTH;
  localparam int unsigned SEL_W = (MASK_DEPTH > 1) ? $clog2(MASK_DEPTH) : 1;

  logic [BUS_W-1:0] bank_q [MASK_DEPTH];

  logic             s1_valid_q;
  logic [BUS_W-1:0] s1_data_q;
  logic [BUS_W-1:0] s1_mask_q;
  logic [1:0]       s1_mode_q;
  logic             s1_last_q;

  logic             s2_load;
  logic             s1_adv;
  logic             accept;
  logic             sel_ok;
  logic [BUS_W-1:0] sel_mask;
  logic [BUS_W-1:0] prod;
  logic [NW-1:0]    prod_zero;

  assign s2_load     = ~bus.out_valid | bus.out_ready;
  assign s1_adv      = s1_valid_q & s2_load;
  assign bus.in_ready = ~s1_valid_q | s1_adv;
  assign accept      = bus.in_valid & bus.in_ready;

  // Mask lookup; a same-cycle write to the selected entry bypasses the bank,
  // and an out-of-range select yields an all-zero mask.
  always_comb begin
    sel_ok   = 1'b0;
    sel_mask = '0;
    for (int unsigned i = 0; i < MASK_DEPTH; i++) begin
      if (bus.in_sel == SEL_W'(i)) begin
        sel_ok   = 1'b1;
        sel_mask = bank_q[i];
      end
    end
    if (sel_ok && bus.mask_wr_en && (bus.mask_wr_addr == bus.in_sel)) begin
      sel_mask = bus.mask_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < MASK_DEPTH; i++) bank_q[i] <= '1;
    end else if (bus.mask_wr_en) begin
      for (int unsigned i = 0; i < MASK_DEPTH; i++) begin
        if (bus.mask_wr_addr == SEL_W'(i)) bank_q[i] <= bus.mask_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mask_q  <= '0;
      s1_mode_q  <= 2'b00;
      s1_last_q  <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_data_q  <= bus.in_data;
      s1_mask_q  <= sel_mask;
      s1_mode_q  <= bus.in_mode;
      s1_last_q  <= bus.in_last;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Mode product and per-word zero flags.
  always_comb begin
    prod      = '0;
    prod_zero = '0;
    case (s1_mode_q)
      2'b00:   prod = s1_data_q & s1_mask_q;
      2'b01:   prod = s1_data_q & ~s1_mask_q;
      2'b10:   prod = s1_data_q;
      default: prod = '0;
    endcase
    for (int unsigned w = 0; w < NW; w++) begin
      prod_zero[w] = (prod[w*PACKET_LENGTH +: PACKET_LENGTH] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_zero  <= '1;
      bus.out_last  <= 1'b0;
    end else if (s2_load) begin
      bus.out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        bus.out_data <= prod;
        bus.out_zero <= prod_zero;
        bus.out_last <= s1_last_q;
      end
    end
  end

  // Beat index of the presented beat; restarts after the frame's last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_beat_cnt <= 16'd0;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_beat_cnt <= bus.out_last ? 16'd0 : bus.out_beat_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err_sel <= 1'b0;
    end else if (accept && !sel_ok) begin
      bus.err_sel <= 1'b1;
    end
  end
endmodule

// File: tb/tb_stream_mask_unit.sv
// Bench for stream_mask_unit (MASK_DEPTH=3): vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_stream_mask_unit;
  localparam int unsigned NW    = 32;
  localparam int unsigned BUS_W = 256;
  localparam int unsigned DEPTH = 3;

  typedef logic [BUS_W-1:0] bus_t;
  typedef logic [NW-1:0]    nw_t;

  typedef struct {
    bus_t d;
    nw_t  z;
    logic last;
  } exp_t;

  typedef struct {
    bus_t        d;
    logic [1:0]  sel;
    logic [1:0]  mode;
    logic        last;
    bus_t        exp_d;
    nw_t         exp_z;
    logic [15:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_mask_unit_if #(.BUS_W(BUS_W), .SEL_W(2), .NW(NW)) bus ();

  stream_mask_unit #(
    .PACKET_LENGTH(8), .W(8), .K_MAX(4), .MASK_DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // reference model state
  bus_t        m_bank [DEPTH];
  exp_t        m_q [$];
  logic [15:0] m_cnt;
  logic        m_err;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bus_t fill(input logic [7:0] b);
    bus_t r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = b;
    return r;
  endfunction

  function automatic bus_t rand_bus();
    bus_t r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bus_t apply_mode(input bus_t d, input bus_t m, input logic [1:0] mode);
    case (mode)
      2'd0:    return d & m;
      2'd1:    return d & ~m;
      2'd2:    return d;
      default: return '0;
    endcase
  endfunction

  function automatic nw_t zero_flags(input bus_t d);
    nw_t z;
    for (int i = 0; i < 32; i++) z[i] = (d[i*8 +: 8] == 8'h00);
    return z;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bank[i] = '1;
    m_q.delete();
    m_cnt = 16'd0;
    m_err = 1'b0;
  endtask

  // One clock cycle: drive, check handshake against the model, advance model.
  task automatic cycle(input logic v, input bus_t d, input logic [1:0] sel,
                       input logic [1:0] mode, input logic last, input logic ordy,
                       input logic wen, input logic [1:0] waddr, input bus_t wdata,
                       output logic acc, output logic hs, output logic rdy,
                       output logic [15:0] hcnt, output nw_t hzero);
    logic        stall;
    bus_t        sv_d;
    nw_t         sv_z;
    logic        sv_l;
    logic [15:0] sv_c;
    exp_t        e;
    bus_t        m;
    @(negedge clk);
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.in_sel       = sel;
    bus.in_mode      = mode;
    bus.in_last      = last;
    bus.out_ready    = ordy;
    bus.mask_wr_en   = wen;
    bus.mask_wr_addr = waddr;
    bus.mask_wr_data = wdata;
    #1;
    rdy = bus.in_ready;
    chk("in_ready", 256'(rdy), 256'((m_q.size() < 2) || ordy));
    acc   = v && bus.in_ready;
    hs    = bus.out_valid && ordy;
    hcnt  = bus.out_beat_cnt;
    hzero = bus.out_zero;
    if (hs) begin
      if (m_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL spurious_out: got out_valid=1 expected no pending beat");
      end else begin
        chk("out_data", bus.out_data, m_q[0].d);
        chk("out_zero", 256'(bus.out_zero), 256'(m_q[0].z));
        chk("out_last", 256'(bus.out_last), 256'(m_q[0].last));
        chk("out_beat_cnt", 256'(bus.out_beat_cnt), 256'(m_cnt));
      end
    end
    stall = bus.out_valid && !ordy;
    sv_d = bus.out_data;
    sv_z = bus.out_zero;
    sv_l = bus.out_last;
    sv_c = bus.out_beat_cnt;
    @(posedge clk);
    #1;
    if (hs && m_q.size() != 0) begin
      m_cnt = m_q[0].last ? 16'd0 : m_cnt + 16'd1;
      void'(m_q.pop_front());
    end
    if (acc) begin
      if (sel >= 2'(DEPTH))                 m = '0;
      else if (wen && waddr == sel)         m = wdata;
      else                                  m = m_bank[sel];
      e.d    = apply_mode(d, m, mode);
      e.z    = zero_flags(e.d);
      e.last = last;
      m_q.push_back(e);
      if (sel >= 2'(DEPTH)) m_err = 1'b1;
    end
    if (wen && waddr < 2'(DEPTH)) m_bank[waddr] = wdata;
    chk("err_sel", 256'(bus.err_sel), 256'(m_err));
    if (stall) begin
      chk("stall_valid", 256'(bus.out_valid), 256'(1'b1));
      chk("stall_data", bus.out_data, sv_d);
      chk("stall_zero", 256'(bus.out_zero), 256'(sv_z));
      chk("stall_last", 256'(bus.out_last), 256'(sv_l));
      chk("stall_cnt", 256'(bus.out_beat_cnt), 256'(sv_c));
    end
  endtask

  task automatic idle(input logic ordy);
    logic a, h, r;
    logic [15:0] c;
    nw_t z;
    cycle(1'b0, '0, 2'd0, 2'd0, 1'b0, ordy, 1'b0, 2'd0, '0, a, h, r, c, z);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 256'(bus.out_valid), 256'(1'b0));
    chk({tag, "_in_ready"}, 256'(bus.in_ready), 256'(1'b1));
    chk({tag, "_out_data"}, bus.out_data, '0);
    chk({tag, "_out_zero"}, 256'(bus.out_zero), 256'(32'hFFFF_FFFF));
    chk({tag, "_out_last"}, 256'(bus.out_last), 256'(1'b0));
    chk({tag, "_out_beat_cnt"}, 256'(bus.out_beat_cnt), 256'(16'd0));
    chk({tag, "_err_sel"}, 256'(bus.err_sel), 256'(1'b0));
  endtask

  vec_t tbl [6];

  initial begin
    bus_t        idx;
    bus_t        bp_data [6];
    bus_t        d;
    logic        a, h, r;
    logic [15:0] c;
    nw_t         z;
    int          sent, got, guard;
    logic        saw_block;
    logic [15:0] fr_cnt [4];
    nw_t         fr_zero [4];
    logic [1:0]  fr_sel [4];
    logic        pat [4];

    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sel = 2'd0; bus.in_mode = 2'd0;
    bus.in_last = 1'b0; bus.out_ready = 1'b1; bus.mask_wr_en = 1'b0;
    bus.mask_wr_addr = 2'd0; bus.mask_wr_data = '0;
    rst = 1'b1;
    model_reset();

    for (int i = 0; i < 32; i++) idx[i*8 +: 8] = 8'(i);
    tbl[0] = '{idx, 2'd0, 2'b10, 1'b0, idx, 32'h0000_0001, 16'd0};
    tbl[1] = '{idx, 2'd0, 2'b10, 1'b0, idx, 32'h0000_0001, 16'd1};
    tbl[2] = '{idx, 2'd0, 2'b10, 1'b0, idx, 32'h0000_0001, 16'd2};
    tbl[3] = '{fill(8'hA5), 2'd1, 2'b00, 1'b0, fill(8'h05), 32'h0, 16'd3};
    tbl[4] = '{fill(8'hA5), 2'd1, 2'b01, 1'b0, fill(8'hA0), 32'h0, 16'd4};
    tbl[5] = '{fill(8'hA5), 2'd1, 2'b11, 1'b1, 256'h0, 32'hFFFF_FFFF, 16'd5};

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // entry 1 = 0x0F in every word
    cycle(1'b0, '0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd1, fill(8'h0F), a, h, r, c, z);

    // table: back-to-back beats, each visible two cycles after it is driven
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc >= 2) begin
        chk("tbl_valid", 256'(bus.out_valid), 256'(1'b1));
        chk("tbl_data", bus.out_data, tbl[cyc-2].exp_d);
        chk("tbl_zero", 256'(bus.out_zero), 256'(tbl[cyc-2].exp_z));
        chk("tbl_last", 256'(bus.out_last), 256'(tbl[cyc-2].last));
        chk("tbl_cnt", 256'(bus.out_beat_cnt), 256'(tbl[cyc-2].exp_cnt));
      end
      bus.out_ready = 1'b1;
      if (cyc < 6) begin
        bus.in_valid = 1'b1;
        bus.in_data  = tbl[cyc].d;
        bus.in_sel   = tbl[cyc].sel;
        bus.in_mode  = tbl[cyc].mode;
        bus.in_last  = tbl[cyc].last;
      end else begin
        bus.in_valid = 1'b0;
      end
    end

    // write bypass, then a later write must not disturb the captured beat
    cycle(1'b1, fill(8'hFF), 2'd2, 2'b00, 1'b0, 1'b1, 1'b1, 2'd2, fill(8'hF0), a, h, r, c, z);
    cycle(1'b0, '0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd2, '0, a, h, r, c, z);
    chk("bypass_valid", 256'(bus.out_valid), 256'(1'b1));
    chk("bypass_data", bus.out_data, fill(8'hF0));
    idle(1'b1);

    // backpressure: out_ready 1,0,0,1 repeating; last beat closes the frame
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    for (int i = 0; i < 6; i++) bp_data[i] = rand_bus();
    sent = 0; got = 0; guard = 0; saw_block = 1'b0;
    while (got < 6 && guard < 60) begin
      cycle(sent < 6, (sent < 6) ? bp_data[sent] : '0, 2'd0, 2'b10, sent == 5,
            pat[guard % 4], 1'b0, 2'd0, '0, a, h, r, c, z);
      if (!r) saw_block = 1'b1;
      if (a) sent++;
      if (h) got++;
      guard++;
    end
    chk("bp_delivered", 256'(got), 256'(6));
    chk("bp_in_ready_dropped", 256'(saw_block), 256'(1'b1));

    // frame boundary and out-of-range select
    fr_sel[0] = 2'd0; fr_sel[1] = 2'd0; fr_sel[2] = 2'd3; fr_sel[3] = 2'd1;
    sent = 0; got = 0; guard = 0;
    while (got < 4 && guard < 30) begin
      cycle(sent < 4, fill(8'h3C), (sent < 4) ? fr_sel[sent] : 2'd0, 2'b00, sent == 1,
            1'b1, 1'b0, 2'd0, '0, a, h, r, c, z);
      if (h) begin
        fr_cnt[got]  = c;
        fr_zero[got] = z;
        got++;
      end
      if (a) sent++;
      guard++;
    end
    chk("frame_delivered", 256'(got), 256'(4));
    chk("frame_cnt0", 256'(fr_cnt[0]), 256'(16'd0));
    chk("frame_cnt1", 256'(fr_cnt[1]), 256'(16'd1));
    chk("frame_cnt2", 256'(fr_cnt[2]), 256'(16'd0));
    chk("frame_cnt3", 256'(fr_cnt[3]), 256'(16'd1));
    chk("frame_sel_err_zero", 256'(fr_zero[2]), 256'(32'hFFFF_FFFF));
    chk("frame_err_sel", 256'(bus.err_sel), 256'(1'b1));
    idle(1'b1);
    chk("err_sel_sticky", 256'(bus.err_sel), 256'(1'b1));

    // mid-stream reset with two beats buffered and downstream stalled
    sent = 0; guard = 0;
    while (sent < 2 && guard < 10) begin
      cycle(1'b1, rand_bus(), 2'd0, 2'b10, 1'b0, 1'b0, 1'b0, 2'd0, '0, a, h, r, c, z);
      if (a) sent++;
      guard++;
    end
    chk("pre_reset_full", 256'(bus.in_ready), 256'(1'b0));
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = fill(8'h77);
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) idle(1'b1);
    d = rand_bus();
    cycle(1'b1, d, 2'd1, 2'b00, 1'b0, 1'b0, 1'b0, 2'd0, '0, a, h, r, c, z);
    idle(1'b0);
    chk("post_reset_bank_ones", bus.out_data, d);
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0), rand_bus(), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 5) == 0),
            2'($urandom_range(0, 3)), rand_bus(), a, h, r, c, z);
    end
    guard = 0;
    while (m_q.size() != 0 && guard < 20) begin
      idle(1'b1);
      guard++;
    end
    chk("drain_empty", 256'(m_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
